// File: rtl/mem_noc_arbiter_pkg.sv
// Shared types for the memory NoC arbiter: FSM states, request/response payloads, default requester count.
package mem_noc_arbiter_pkg;

  localparam int MEM_NOC_MST_NUM = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } mem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        last;
  } mem_resp_t;

endpackage

// File: rtl/mem_noc_arbiter_if.sv
// Request/response handshake bundle with N request lanes and a single broadcast response payload.
interface mem_noc_arbiter_if
  import mem_noc_arbiter_pkg::*;
#(
  parameter int N = 1
);

  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  mem_req_t     req [N];
  logic [N-1:0] resp_valid;
  logic [N-1:0] resp_ready;
  mem_resp_t    resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );

endinterface

// File: rtl/mem_noc_arbiter_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping; returns one-hot and id.
module mem_noc_arbiter_rr_arb #(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every output gets a default before the search so no path leaves a value held (no latch).
    gnt    = '0;
    gnt_id = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[ID_W'(idx)]) begin
        found              = 1'b1;
        gnt[ID_W'(idx)]    = 1'b1;
        gnt_id             = ID_W'(idx);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mem_noc_arbiter.sv
// N-to-1 round-robin arbiter for the memory NoC master port; one locked transaction per grant.
// Optional build macro MEM_NOC_ARB_PERF_EN adds per-requester saturating grant counters.
module mem_noc_arbiter
  import mem_noc_arbiter_pkg::*;
#(
  parameter int MST_NUM  = MEM_NOC_MST_NUM,
  parameter int MST_ID_W = $clog2(MST_NUM)
) (
  input  logic                clk,
  input  logic                rstn,
  mem_noc_arbiter_if.slave    m,
  mem_noc_arbiter_if.master   s,
  output logic [MST_ID_W-1:0] gnt_id,
  output logic                busy
`ifdef MEM_NOC_ARB_PERF_EN
  ,
  output logic [31:0]         perf_gnt_cnt [MST_NUM]
`endif
);

  mem_arb_state_t      state;
  logic [MST_ID_W-1:0] rr_ptr;
  logic [MST_NUM-1:0]  sel_oh;
  logic [MST_ID_W-1:0] sel_id;
  logic                sel_any;
  logic [MST_ID_W-1:0] cur_id;
  logic                req_hs;
  logic                resp_done;

  function automatic logic [MST_ID_W-1:0] wrap_inc(input logic [MST_ID_W-1:0] id);
    return (id == MST_ID_W'(MST_NUM - 1)) ? '0 : id + MST_ID_W'(1);
  endfunction

  mem_noc_arbiter_rr_arb #(.N(MST_NUM), .ID_W(MST_ID_W)) u_rr_arb (
    .req    (m.req_valid),
    .ptr    (rr_ptr),
    .gnt    (sel_oh),
    .gnt_id (sel_id),
    .any    (sel_any)
  );

  // Outside IDLE the grant is frozen on gnt_id; new arrivals never steal it.
  always_comb begin
    cur_id          = (state == ARB_IDLE) ? sel_id : gnt_id;
    s.req_valid     = 1'b0;
    s.req[0]        = m.req[cur_id];
    s.resp_ready    = 1'b0;
    m.req_ready     = '0;
    m.resp_valid    = '0;
    m.resp          = s.resp;
    unique case (state)
      ARB_IDLE: begin
        s.req_valid         = sel_any;
        m.req_ready[cur_id] = sel_any & s.req_ready[0];
      end
      ARB_REQ: begin
        s.req_valid         = m.req_valid[gnt_id];
        m.req_ready[cur_id] = m.req_valid[gnt_id] & s.req_ready[0];
      end
      ARB_RESP: begin
        m.resp_valid[gnt_id] = s.resp_valid[0];
        s.resp_ready         = m.resp_ready[gnt_id];
      end
      default: ;
    endcase
  end

  assign req_hs    = s.req_valid[0] & s.req_ready[0];
  assign resp_done = (state == ARB_RESP) & s.resp_valid[0] & s.resp_ready[0] & s.resp.last;
  assign busy      = (state != ARB_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (sel_any) begin
            gnt_id <= sel_id;
            if (req_hs) begin
              state  <= ARB_RESP;
              rr_ptr <= wrap_inc(sel_id);
            end else begin
              state  <= ARB_REQ;
            end
          end
        end
        ARB_REQ: begin
          if (req_hs) begin
            state  <= ARB_RESP;
            rr_ptr <= wrap_inc(gnt_id);
          end
        end
        ARB_RESP: begin
          if (resp_done) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_NOC_ARB_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MST_NUM; i++) perf_gnt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < MST_NUM; i++) begin
        if (req_hs && cur_id == MST_ID_W'(i) && perf_gnt_cnt[i] != 32'hFFFF_FFFF)
          perf_gnt_cnt[i] <= perf_gnt_cnt[i] + 32'd1;
      end
    end
  end
`endif

  // Router must not present a response unless a transaction is outstanding.
  a_resp_only_in_resp: assert property (@(posedge clk) disable iff (!rstn)
    s.resp_valid[0] |-> state == ARB_RESP);

  // A granted requester must keep its request up until it is accepted.
  a_req_held: assert property (@(posedge clk) disable iff (!rstn)
    state == ARB_REQ |-> m.req_valid[gnt_id]);

endmodule

// File: tb/tb_mem_noc_arbiter.sv
// Directed bench for mem_noc_arbiter: the bench plays both requesters and the router side.
module tb_mem_noc_arbiter;
  import mem_noc_arbiter_pkg::*;

  localparam int N = 2;
  localparam logic [31:0] ADDR0 = 32'h0000_1000;
  localparam logic [31:0] ADDR1 = 32'h0000_2000;

  logic clk = 1'b0;
  logic rstn;
  logic [0:0] gnt_id;
  logic busy;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_noc_arbiter_if #(.N(N)) m_if ();
  mem_noc_arbiter_if #(.N(1)) s_if ();

`ifdef MEM_NOC_ARB_PERF_EN
  logic [31:0] perf [N];
`endif

  mem_noc_arbiter #(.MST_NUM(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .m      (m_if),
    .s      (s_if),
    .gnt_id (gnt_id),
    .busy   (busy)
`ifdef MEM_NOC_ARB_PERF_EN
    ,
    .perf_gnt_cnt (perf)
`endif
  );

  task automatic idle_inputs();
    m_if.req_valid  = '0;
    m_if.resp_ready = '0;
    m_if.req[0]     = '{addr: ADDR0, wdata: 32'h1111_0000, wstrb: 4'hF, we: 1'b1};
    m_if.req[1]     = '{addr: ADDR1, wdata: 32'h2222_0000, wstrb: 4'h3, we: 1'b0};
    s_if.req_ready  = '0;
    s_if.resp_valid = '0;
    s_if.resp       = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Called at a negedge in ARB_RESP; returns at the following negedge (back in IDLE).
  task automatic finish_resp();
    s_if.resp_valid = 1'b1;
    s_if.resp       = '{rdata: 32'hDEAD_0000, err: 1'b0, last: 1'b1};
    m_if.resp_ready = '1;
    @(negedge clk);
    s_if.resp_valid = 1'b0;
    m_if.resp_ready = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    m_if.req_valid = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vecs++; if (gnt_id !== 1'b0) begin errs++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    vecs++; if (m_if.req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready: got %b want 00", m_if.req_ready); end
    vecs++; if (m_if.resp_valid !== 2'b00) begin errs++; $display("FAIL reset_resp_valid: got %b want 00", m_if.resp_valid); end
    vecs++; if (s_if.resp_ready !== 1'b0) begin errs++; $display("FAIL reset_s_resp_ready: got %b want 0", s_if.resp_ready); end
    vecs++; if (s_if.req_valid !== 1'b1) begin errs++; $display("FAIL reset_s_req_valid_comb: got %b want 1", s_if.req_valid); end
    m_if.req_valid = 2'b00;
    #1;
    vecs++; if (s_if.req_valid !== 1'b0) begin errs++; $display("FAIL reset_s_req_valid_idle: got %b want 0", s_if.req_valid); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_grant();
    @(negedge clk);
    m_if.req_valid = 2'b01;
    s_if.req_ready = 1'b1;
    #1;
    vecs++; if (s_if.req_valid !== 1'b1) begin errs++; $display("FAIL single_s_req_valid: got %b want 1", s_if.req_valid); end
    vecs++; if (m_if.req_ready !== 2'b01) begin errs++; $display("FAIL single_req_ready: got %b want 01", m_if.req_ready); end
    vecs++; if (s_if.req[0].addr !== ADDR0) begin errs++; $display("FAIL single_s_req_addr: got %h want %h", s_if.req[0].addr, ADDR0); end
    @(negedge clk);
    m_if.req_valid = 2'b00;
    s_if.req_ready = 1'b0;
    #1;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", busy); end
    vecs++; if (gnt_id !== 1'b0) begin errs++; $display("FAIL single_gnt_id: got %0d want 0", gnt_id); end
    s_if.resp_valid = 1'b1;
    s_if.resp       = '{rdata: 32'hA5A5_0001, err: 1'b0, last: 1'b1};
    m_if.resp_ready = 2'b01;
    #1;
    vecs++; if (m_if.resp_valid !== 2'b01) begin errs++; $display("FAIL single_resp_valid: got %b want 01", m_if.resp_valid); end
    vecs++; if (s_if.resp_ready !== 1'b1) begin errs++; $display("FAIL single_s_resp_ready: got %b want 1", s_if.resp_ready); end
    vecs++; if (m_if.resp.rdata !== 32'hA5A5_0001) begin errs++; $display("FAIL single_resp_data: got %h want a5a50001", m_if.resp.rdata); end
    @(negedge clk);
    s_if.resp_valid = 1'b0;
    m_if.resp_ready = 2'b00;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_after_last: got busy %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    m_if.req_valid  = 2'b11;
    m_if.resp_ready = 2'b11;
    s_if.req_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  oh;
      logic [31:0] addr;
      oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
      addr = (k % 2 == 0) ? ADDR0 : ADDR1;
      #1;
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_idle_%0d: got busy %b want 0", k, busy); end
      vecs++; if (m_if.req_ready !== oh) begin errs++; $display("FAIL rr_grant_%0d: got %b want %b", k, m_if.req_ready, oh); end
      vecs++; if (s_if.req[0].addr !== addr) begin errs++; $display("FAIL rr_addr_%0d: got %h want %h", k, s_if.req[0].addr, addr); end
      @(negedge clk);
      s_if.resp_valid = 1'b1;
      s_if.resp       = '{rdata: 32'(k), err: 1'b0, last: 1'b1};
      #1;
      vecs++; if (gnt_id !== oh[1]) begin errs++; $display("FAIL rr_gnt_id_%0d: got %0d want %0d", k, gnt_id, oh[1]); end
      vecs++; if (m_if.resp_valid !== oh) begin errs++; $display("FAIL rr_resp_valid_%0d: got %b want %b", k, m_if.resp_valid, oh); end
      vecs++; if (m_if.req_ready !== 2'b00) begin errs++; $display("FAIL rr_no_reissue_%0d: got %b want 00", k, m_if.req_ready); end
      @(negedge clk);
      s_if.resp_valid = 1'b0;
    end
    m_if.req_valid  = 2'b00;
    m_if.resp_ready = 2'b00;
    s_if.req_ready  = 1'b0;
  endtask

  task automatic test_grant_hold();
    do_reset();
    @(negedge clk);
    m_if.req_valid = 2'b01;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      m_if.req_valid = 2'b11;
      #1;
      vecs++; if (gnt_id !== 1'b0) begin errs++; $display("FAIL hold_gnt_id_%0d: got %0d want 0", c, gnt_id); end
      vecs++; if (s_if.req[0].addr !== ADDR0) begin errs++; $display("FAIL hold_addr_%0d: got %h want %h", c, s_if.req[0].addr, ADDR0); end
      vecs++; if (s_if.req_valid !== 1'b1) begin errs++; $display("FAIL hold_s_req_valid_%0d: got %b want 1", c, s_if.req_valid); end
      vecs++; if (m_if.req_ready !== 2'b00) begin errs++; $display("FAIL hold_req_ready_%0d: got %b want 00", c, m_if.req_ready); end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL hold_busy_%0d: got %b want 1", c, busy); end
      @(negedge clk);
    end
    s_if.req_ready = 1'b1;
    #1;
    vecs++; if (m_if.req_ready !== 2'b01) begin errs++; $display("FAIL hold_accept: got %b want 01", m_if.req_ready); end
    @(negedge clk);
    m_if.req_valid = 2'b00;
    s_if.req_ready = 1'b0;
    #1;
    vecs++; if (gnt_id !== 1'b0) begin errs++; $display("FAIL hold_gnt_after: got %0d want 0", gnt_id); end
    finish_resp();
  endtask

  task automatic test_multibeat();
    logic [31:0] rd   [5] = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    logic        lst  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  rdy  [5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    logic        exp_r[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    @(negedge clk);
    m_if.req_valid = 2'b01;
    s_if.req_ready = 1'b1;
    @(negedge clk);
    m_if.req_valid = 2'b00;
    s_if.req_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      s_if.resp_valid = 1'b1;
      s_if.resp       = '{rdata: rd[b], err: 1'b0, last: lst[b]};
      m_if.resp_ready = rdy[b];
      #1;
      vecs++; if (s_if.resp_ready !== exp_r[b]) begin errs++; $display("FAIL mb_s_resp_ready_%0d: got %b want %b", b, s_if.resp_ready, exp_r[b]); end
      vecs++; if (m_if.resp_valid !== 2'b01) begin errs++; $display("FAIL mb_resp_valid_%0d: got %b want 01", b, m_if.resp_valid); end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mb_busy_%0d: got %b want 1", b, busy); end
      vecs++; if (m_if.resp.rdata !== rd[b]) begin errs++; $display("FAIL mb_data_%0d: got %h want %h", b, m_if.resp.rdata, rd[b]); end
      @(negedge clk);
    end
    s_if.resp_valid = 1'b0;
    m_if.resp_ready = 2'b00;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mb_idle_after_last: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m_if.req_valid = 2'b01;
    s_if.req_ready = 1'b1;
    @(negedge clk);
    m_if.req_valid  = 2'b00;
    s_if.req_ready  = 1'b0;
    s_if.resp_valid = 1'b1;
    s_if.resp       = '{rdata: 32'hC0DE_0000, err: 1'b0, last: 1'b0};
    m_if.resp_ready = 2'b01;
    #1;
    rstn = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vecs++; if (gnt_id !== 1'b0) begin errs++; $display("FAIL rmid_gnt_id: got %0d want 0", gnt_id); end
    vecs++; if (m_if.resp_valid !== 2'b00) begin errs++; $display("FAIL rmid_resp_valid: got %b want 00", m_if.resp_valid); end
    vecs++; if (s_if.resp_ready !== 1'b0) begin errs++; $display("FAIL rmid_s_resp_ready: got %b want 0", s_if.resp_ready); end
    vecs++; if (s_if.req_valid !== 1'b0) begin errs++; $display("FAIL rmid_s_req_valid: got %b want 0", s_if.req_valid); end
    @(negedge clk);
    s_if.resp_valid = 1'b0;
    m_if.resp_ready = 2'b00;
    rstn = 1'b1;
    @(negedge clk);
    m_if.req_valid = 2'b11;
    s_if.req_ready = 1'b1;
    #1;
    vecs++; if (m_if.req_ready !== 2'b01) begin errs++; $display("FAIL rmid_ptr_reset: got %b want 01", m_if.req_ready); end
    @(negedge clk);
    m_if.req_valid = 2'b00;
    s_if.req_ready = 1'b0;
    finish_resp();
  endtask

`ifdef MEM_NOC_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      m_if.req_valid = 2'b10;
      s_if.req_ready = 1'b1;
      @(negedge clk);
      m_if.req_valid = 2'b00;
      s_if.req_ready = 1'b0;
      finish_resp();
    end
    #1;
    vecs++; if (perf[1] !== 32'd5) begin errs++; $display("FAIL perf_cnt1: got %0d want 5", perf[1]); end
    vecs++; if (perf[0] !== 32'd0) begin errs++; $display("FAIL perf_cnt0: got %0d want 0", perf[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_grant_hold();
    test_multibeat();
    test_reset_mid();
`ifdef MEM_NOC_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
